// File: rtl/sr_nd_pkg.sv
// Shared types for the clocked SR flag array: {q,qb} state encoding and reset value.
// No logic; imported by sr_nd and sr_nd_cell.
package sr_nd_pkg;

    typedef enum logic [1:0] {
        SR_BAD = 2'b00,
        SR_RST = 2'b01,
        SR_SET = 2'b10
    } sr_state_e;

    localparam sr_state_e SR_RESET_STATE = SR_RST;

endpackage

// File: rtl/sr_nd_cell.sv
// Single clocked SR lane; q/qb/illegal registered, 1 clk from s/r sample to output.
// No backpressure: s/r are sampled on every rising edge.
module sr_nd_cell
    import sr_nd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qb,
    output logic illegal
);

    sr_state_e state_q;
    logic      illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SR_RESET_STATE;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= s & r;
            case ({s, r})
                // A forbidden lane never holds 0/0; releasing both inputs lands in reset.
                2'b00:   state_q <= (state_q == SR_BAD) ? SR_RST : state_q;
                2'b01:   state_q <= SR_RST;
                2'b10:   state_q <= SR_SET;
                default: state_q <= SR_BAD;
            endcase
        end
    end

    assign q       = state_q[1];
    assign qb      = state_q[0];
    assign illegal = illegal_q;

endmodule

// File: rtl/sr_nd.sv
// WIDTH independent clocked SR flag lanes; outputs registered, 1 clk latency.
// No backpressure: s/r are sampled on every rising edge.
module sr_nd
    import sr_nd_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] illegal
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sr_nd_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .s       (s[i]),
            .r       (r[i]),
            .q       (q[i]),
            .qb      (qb[i]),
            .illegal (illegal[i])
        );
    end

endmodule

// File: tb/tb_sr_nd.sv
// Directed table-driven bench for sr_nd (WIDTH=4), plus a registered-output check.
module tb_sr_nd;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic [W-1:0] illegal;

    int n_cmp;
    int n_bad;

    sr_nd #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s       (s),
        .r       (r),
        .q       (q),
        .qb      (qb),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic [W-1:0] q;
        logic [W-1:0] qb;
        logic [W-1:0] il;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rn, logic [W-1:0] sv, logic [W-1:0] rv,
                                logic [W-1:0] qv, logic [W-1:0] qbv, logic [W-1:0] ilv);
        vec_t v;
        v.rst_n = rn;
        v.s     = sv;
        v.r     = rv;
        v.q     = qv;
        v.qb    = qbv;
        v.il    = ilv;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Reset held with set requested, then release: set lands on next edge.
        vecs.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0));
        vecs.push_back(mk(1'b0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0));
        vecs.push_back(mk(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0));
        // Truth table after a fresh reset: 00, 01, 10, 11.
        vecs.push_back(mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0));
        vecs.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0));
        vecs.push_back(mk(1'b1, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0));
        vecs.push_back(mk(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0));
        vecs.push_back(mk(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF));
        // Forbidden exits: 11->00 goes to reset, 11->10 goes to set.
        vecs.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0));
        vecs.push_back(mk(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF));
        vecs.push_back(mk(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0));
        // Hold set for 5 clocks.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0));
        // Reset while forbidden clears illegal on the same edge.
        vecs.push_back(mk(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF));
        vecs.push_back(mk(1'b0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0));
        // Lane independence from all-reset: lane0 11, lane1 01, lane2 10, lane3 hold.
        vecs.push_back(mk(1'b1, 4'b0101, 4'b0011, 4'b0100, 4'b1010, 4'b0001));
        // Forbidden exit 11->01 on lane 0, and lane 3 set independently.
        vecs.push_back(mk(1'b1, 4'b1000, 4'b0001, 4'b1100, 4'b0011, 4'b0000));
        // Same pattern again: lane3 holds set, lane2 re-sets, lane0 forbidden.
        vecs.push_back(mk(1'b1, 4'b0101, 4'b0011, 4'b1100, 4'b0010, 4'b0001));
        // Forbidden exit via 00 while other lanes hold.
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b1100, 4'b0011, 4'b0000));

        rst_n = vecs[0].rst_n;
        s     = vecs[0].s;
        r     = vecs[0].r;

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            s     = vecs[i].s;
            r     = vecs[i].r;
            @(posedge clk);
            @(negedge clk);
            check("q",       i, q,       vecs[i].q);
            check("qb",      i, qb,      vecs[i].qb);
            check("illegal", i, illegal, vecs[i].il);
        end

        // Outputs must not follow s/r before the next edge (state is 1100/0011/0000).
        rst_n = 1'b1;
        s     = 4'b0011;
        r     = 4'b1111;
        #1;
        check("q_nocomb",  100, q,       4'b1100);
        check("qb_nocomb", 100, qb,      4'b0011);
        check("il_nocomb", 100, illegal, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        check("q_after",   101, q,       4'b0000);
        check("qb_after",  101, qb,      4'b1100);
        check("il_after",  101, illegal, 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
